conv2d_stream: RTL and testbench

CONV2D_STREAM -- requirements
Module: conv2d_stream

---
 rtl/conv_pkg.sv | 30 +++
 rtl/conv2d_stream_if.sv | 22 ++
 rtl/conv_mac_tree.sv | 56 +++++
 rtl/conv2d_stream.sv | 95 +++++++++
 tb/tb_conv2d_stream.sv | 193 +++++++++++++++++++
 5 files changed

// File: rtl/conv_pkg.sv
// Shared helpers for the streaming 2-D convolution: width math and the
// saturate/relu output clamp.
package conv_pkg;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++)
      if ((1 << r) < v) r++;
    return r;
  endfunction

  // Full-precision accumulator: K*K double-width products plus carry growth.
  function automatic int acc_width(input int dw, input int kk);
    return 2 * dw + clog2(kk);
  endfunction

  localparam int ACC_W_DEF = acc_width(16, 9);

  function automatic logic signed [63:0] sat_relu(input logic signed [63:0] v,
                                                  input int dw, input logic relu);
    logic signed [63:0] hi, lo, r;
    hi = (64'sd1 <<< (dw - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (dw - 1));
    r  = (v > hi) ? hi : (v < lo) ? lo : v;
    if (relu && r < 0) r = '0;
    return r;
  endfunction

endpackage

// File: rtl/conv2d_stream_if.sv
// Pixel stream, weight-write port and result stream of conv2d_stream.
interface conv2d_stream_if #(
  parameter int DATA_WIDTH = 16,
  parameter int K_SIZE     = 3
);
  localparam int AW = conv_pkg::clog2(K_SIZE * K_SIZE + 1);

  logic                  in_valid;
  logic                  in_sof;
  logic [DATA_WIDTH-1:0] in_data;
  logic                  relu_en;
  logic                  w_we;
  logic [AW-1:0]         w_addr;
  logic [DATA_WIDTH-1:0] w_data;
  logic                  out_valid;
  logic [DATA_WIDTH-1:0] out_data;

  modport master (output in_valid, in_sof, in_data, relu_en, w_we, w_addr, w_data,
                  input  out_valid, out_data);
  modport slave  (input  in_valid, in_sof, in_data, relu_en, w_we, w_addr, w_data,
                  output out_valid, out_data);
endinterface

// File: rtl/conv_mac_tree.sv
// Two-stage MAC: multiply-add of the window against current weights plus bias,
// registered; then shift by Q, saturate, optional relu, registered.
module conv_mac_tree
  import conv_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int Q          = 5,
  parameter int K_SIZE     = 3
) (
  input  logic                                          clk,
  input  logic                                          rst,
  input  logic                                          in_vld,
  input  logic                                          relu_en,
  input  logic [K_SIZE*K_SIZE-1:0][DATA_WIDTH-1:0]      win,
  input  logic [K_SIZE*K_SIZE-1:0][DATA_WIDTH-1:0]      wts,
  input  logic [DATA_WIDTH-1:0]                         bias,
  output logic                                          out_valid,
  output logic [DATA_WIDTH-1:0]                         out_data
);
  localparam int KK     = K_SIZE * K_SIZE;
  localparam int ACC_W  = acc_width(DATA_WIDTH, KK);
  localparam int STAGES = 1;

  logic signed [2*DATA_WIDTH-1:0] prod [KK];
  logic signed [ACC_W-1:0]        acc, acc_q;
  logic                           relu_q;
  logic [STAGES:0]                vld_pipe;

  for (genvar i = 0; i < KK; i++) begin : g_mul
    assign prod[i] = (2*DATA_WIDTH)'($signed(win[i])) * (2*DATA_WIDTH)'($signed(wts[i]));
  end

  always_comb begin
    acc = ACC_W'($signed(bias)) <<< Q;
    for (int i = 0; i < KK; i++) acc = acc + ACC_W'(prod[i]);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_pipe <= '0;
      acc_q    <= '0;
      relu_q   <= 1'b0;
      out_data <= '0;
    end else begin
      vld_pipe <= {vld_pipe[STAGES-1:0], in_vld};
      if (in_vld) begin
        acc_q  <= acc;
        relu_q <= relu_en;
      end
      if (vld_pipe[0])
        out_data <= DATA_WIDTH'(sat_relu(64'(acc_q >>> Q), DATA_WIDTH, relu_q));
    end
  end

  assign out_valid = vld_pipe[STAGES];
endmodule

// File: rtl/conv2d_stream.sv
// Streaming KxK convolution over raster-order pixels: line buffers, sliding
// window, weight/bias registers and a two-stage MAC tree.
module conv2d_stream
  import conv_pkg::*;
#(
  parameter int IMG_W      = 8,
  parameter int IMG_H      = 8,
  parameter int DATA_WIDTH = 16,
  parameter int Q          = 5,
  parameter int K_SIZE     = 3
) (
  input  logic            clk,
  input  logic            rst,
  conv2d_stream_if.slave  bus
);
  localparam int KK = K_SIZE * K_SIZE;
  localparam int CW = clog2(IMG_W);
  localparam int RW = clog2(IMG_H);
  localparam int AW = clog2(KK + 1);

  logic [CW-1:0] col, col_eff;
  logic [RW-1:0] row, row_eff;
  logic          win_vld;

  logic [DATA_WIDTH-1:0]                          lb [K_SIZE-1][IMG_W];
  logic [K_SIZE-1:0][K_SIZE-2:0][DATA_WIDTH-1:0]  hist;
  logic [KK-1:0][DATA_WIDTH-1:0]                  win_next, wts;
  logic [DATA_WIDTH-1:0]                          bias;

  // Window that includes the pixel being accepted; the MAC multiplies it in
  // the acceptance cycle so a same-cycle weight write is not yet visible.
  always_comb begin
    col_eff  = bus.in_sof ? '0 : col;
    row_eff  = bus.in_sof ? '0 : row;
    win_vld  = bus.in_valid && (row_eff >= RW'(K_SIZE - 1)) && (col_eff >= CW'(K_SIZE - 1));
    win_next = '0;
    for (int r = 0; r < K_SIZE; r++)
      for (int k = 0; k < K_SIZE - 1; k++)
        win_next[r*K_SIZE + k] = hist[r][k];
    for (int r = 0; r < K_SIZE - 1; r++)
      win_next[r*K_SIZE + K_SIZE - 1] = lb[K_SIZE - 2 - r][col_eff];
    win_next[KK - 1] = bus.in_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      col  <= '0;
      row  <= '0;
      wts  <= '0;
      bias <= '0;
    end else begin
      if (bus.in_valid) begin
        if (col_eff == CW'(IMG_W - 1)) begin
          col <= '0;
          row <= (row_eff == RW'(IMG_H - 1)) ? '0 : row_eff + RW'(1);
        end else begin
          col <= col_eff + CW'(1);
          row <= row_eff;
        end
      end
      if (bus.w_we) begin
        if (bus.w_addr < AW'(KK))       wts[bus.w_addr] <= bus.w_data;
        else if (bus.w_addr == AW'(KK)) bias            <= bus.w_data;
      end
    end
  end

  // Pixel storage is never cleared; stale data is hidden by win_vld masking.
  always_ff @(posedge clk) begin
    if (bus.in_valid) begin
      for (int r = 0; r < K_SIZE; r++)
        for (int k = 0; k < K_SIZE - 1; k++)
          hist[r][k] <= win_next[r*K_SIZE + k + 1];
      lb[0][col_eff] <= bus.in_data;
      for (int j = 1; j < K_SIZE - 1; j++)
        lb[j][col_eff] <= lb[j-1][col_eff];
    end
  end

  conv_mac_tree #(
    .DATA_WIDTH (DATA_WIDTH),
    .Q          (Q),
    .K_SIZE     (K_SIZE)
  ) u_mac (
    .clk       (clk),
    .rst       (rst),
    .in_vld    (win_vld),
    .relu_en   (bus.relu_en),
    .win       (win_next),
    .wts       (wts),
    .bias      (bias),
    .out_valid (bus.out_valid),
    .out_data  (bus.out_data)
  );
endmodule

// File: tb/tb_conv2d_stream.sv
// Directed bench for conv2d_stream (8x8 image, 3x3 kernel, Q=5).
module tb_conv2d_stream;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  conv2d_stream_if #(.DATA_WIDTH(16), .K_SIZE(3)) bus();

  conv2d_stream #(
    .IMG_W(8), .IMG_H(8), .DATA_WIDTH(16), .Q(5), .K_SIZE(3)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks   = 0;
  int failures = 0;
  int t22      = 0;
  logic [15:0] outq[$];
  int          ocyc[$];

  always @(negedge clk)
    if (bus.out_valid) begin
      outq.push_back(bus.out_data);
      ocyc.push_back(cyc);
    end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    bus.in_valid = 1'b0;
    bus.in_sof   = 1'b0;
    bus.w_we     = 1'b0;
  endtask

  task automatic wr(input int a, input logic [15:0] d);
    bus.w_we   = 1'b1;
    bus.w_addr = 4'(a);
    bus.w_data = d;
    tick();
    bus.w_we   = 1'b0;
  endtask

  task automatic set_taps(input logic [15:0] t, input logic [15:0] ctr, input logic [15:0] b);
    for (int i = 0; i < 9; i++) wr(i, (i == 4) ? ctr : t);
    wr(9, b);
  endtask

  // mode 0: constant px; mode 1: ramp (r*8+c)<<5. gap: percent idle cycles.
  task automatic send(input int mode, input logic [15:0] px, input int gap,
                      input int npix, input bit wr22);
    for (int p = 0; p < npix; p++) begin
      int r = p / 8;
      int c = p % 8;
      while (int'($urandom_range(99)) < gap) begin
        idle_in();
        tick();
      end
      bus.in_valid = 1'b1;
      bus.in_sof   = (p == 0);
      bus.in_data  = (mode == 1) ? 16'((r * 8 + c) << 5) : px;
      if (r == 2 && c == 2) begin
        t22 = cyc;
        if (wr22) begin
          bus.w_we   = 1'b1;
          bus.w_addr = 4'd4;
          bus.w_data = 16'h0040;
        end
      end
      tick();
      bus.w_we = 1'b0;
    end
    idle_in();
  endtask

  // kind 0: all a; kind 1: ramp pixel (r-1,c-1) + a; kind 2: first a, rest b.
  task automatic check_frame(input string tag, input int kind,
                             input logic [15:0] a, input logic [15:0] b);
    logic [15:0] e_last;
    repeat (4) tick();
    chk({tag, "_cnt"}, outq.size(), 36);
    if (outq.size() > 0) chk({tag, "_lat"}, ocyc[0], t22 + 2);
    for (int i = 0; i < 36 && i < outq.size(); i++) begin
      int r = i / 6 + 2;
      int c = i % 6 + 2;
      logic [15:0] e;
      case (kind)
        0:       e = a;
        1:       e = 16'((((r - 1) * 8 + (c - 1)) << 5) + a);
        default: e = (i == 0) ? a : b;
      endcase
      chk($sformatf("%s_v%0d", tag, i), outq[i], e);
    end
    case (kind)
      0:       e_last = a;
      1:       e_last = 16'(((6 * 8 + 6) << 5) + a);
      default: e_last = b;
    endcase
    chk({tag, "_idle"}, bus.out_valid, 0);
    chk({tag, "_hold"}, bus.out_data, e_last);
    outq.delete();
    ocyc.delete();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout got=%0d exp=done", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    rst         = 1'b1;
    idle_in();
    bus.relu_en = 1'b0;
    bus.w_addr  = '0;
    bus.w_data  = '0;
    bus.in_data = '0;
    repeat (3) tick();
    rst = 1'b0;
    chk("rst_valid", bus.out_valid, 0);
    chk("rst_data", bus.out_data, 0);
    tick();
    chk("rst_valid2", bus.out_valid, 0);

    // Box filter of 1.0 over a flat 1.0 frame -> 9.0 everywhere
    set_taps(16'h0020, 16'h0020, 16'h0000);
    send(0, 16'h0020, 0, 64, 1'b0);
    check_frame("ones", 0, 16'h0120, 16'h0);

    // Centre tap only -> output echoes pixel (r-1,c-1)
    set_taps(16'h0000, 16'h0020, 16'h0000);
    send(1, 16'h0, 0, 64, 1'b0);
    check_frame("ctr", 1, 16'h0, 16'h0);

    // Bias adds its raw value to the result
    wr(9, 16'h0010);
    send(1, 16'h0, 0, 64, 1'b0);
    check_frame("ctr_bias", 1, 16'h0010, 16'h0);

    // Saturation and relu
    set_taps(16'h0020, 16'h0020, 16'h0000);
    send(0, 16'h7FFF, 0, 64, 1'b0);
    check_frame("sat_hi", 0, 16'h7FFF, 16'h0);
    send(0, 16'h8000, 0, 64, 1'b0);
    check_frame("sat_lo", 0, 16'h8000, 16'h0);
    bus.relu_en = 1'b1;
    send(0, 16'h8000, 0, 64, 1'b0);
    check_frame("relu", 0, 16'h0000, 16'h0);
    bus.relu_en = 1'b0;

    // Idle gaps in the stream
    send(0, 16'h0020, 40, 64, 1'b0);
    check_frame("gaps", 0, 16'h0120, 16'h0);

    // Reset mid-frame: in-flight result for (2,3) must be dropped
    send(0, 16'h0020, 0, 20, 1'b0);
    rst = 1'b1;
    tick();
    chk("abort_valid", bus.out_valid, 0);
    chk("abort_data", bus.out_data, 0);
    rst = 1'b0;
    outq.delete();
    ocyc.delete();
    tick();
    chk("abort_after", bus.out_valid, 0);
    set_taps(16'h0020, 16'h0020, 16'h0000);
    chk("abort_quiet", outq.size(), 0);
    send(0, 16'h0020, 0, 64, 1'b0);
    check_frame("rst_frame", 0, 16'h0120, 16'h0);

    // Tap write coincident with pixel (2,2): old tap for (2,2), new from (2,3)
    send(0, 16'h0020, 0, 64, 1'b1);
    check_frame("wr_race", 2, 16'h0120, 16'h0140);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
